code_player: RTL and testbench

- Transmit-side counterpart to the switch-entry combination lock: plays a stored 5-digit code out on LED1..LED4, one digit at a time, so an operator can read it and key it back in on SW1..SW4.
- Each digit lights exactly one LED for a fixed on-time, then all LEDs go dark for a fixed gap before the next digit.
- Sits on the icestick top level next to the lock; triggered by a one-cycle start pulse from a debounced button or from the top-level FSM.

---
 rtl/code_player_pkg.sv | 29 ++
 rtl/code_player_tick_timer.sv | 42 ++++
 rtl/code_player.sv | 143 ++++++++++++++
 tb/tb_code_player.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/code_player_pkg.sv
// Shared definitions for the code playback block: state encoding, digit-to-LED
// mapping and the default secret code.
package code_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int unsigned LED_W        = 4;
    localparam logic [9:0]  DEFAULT_CODE = 10'h390;

    function automatic logic [LED_W-1:0] digit_to_led(input logic [1:0] digit);
        logic [LED_W-1:0] led;
        case (digit)
            2'd0:    led = 4'b0001;
            2'd1:    led = 4'b0010;
            2'd2:    led = 4'b0100;
            default: led = 4'b1000;
        endcase
        return led;
    endfunction

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/code_player_tick_timer.sv
// Loadable up/down tick counter with a terminal-count flag; holds at the
// terminal value instead of wrapping.
module tick_timer
    import code_player_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             down,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc    = (count_q == term);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && !tc) begin
            count_d = down ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/code_player.sv
// Plays a captured multi-digit code on four LEDs, one lit LED per digit
// followed by a dark gap; all outputs are registered.
module code_player
    import code_player_pkg::*;
#(
    parameter int unsigned CODE_LEN  = 5,
    parameter int unsigned ON_TICKS  = 6000000,
    parameter int unsigned OFF_TICKS = 3000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*CODE_LEN-1:0] code,
    output logic [3:0]            led,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W = clog2_min1((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
    localparam int unsigned IDX_W = clog2_min1(CODE_LEN);

    localparam logic [CNT_W-1:0] ON_TERM  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_TERM = CNT_W'(OFF_TICKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [2*CODE_LEN-1:0] code_q, code_d;
    logic [3:0]            led_q, led_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  tmr_load;
    logic                  tmr_en;
    logic [CNT_W-1:0]      tmr_term;
    logic [CNT_W-1:0]      tmr_count;
    logic                  tmr_tc;

    logic [IDX_W-1:0]      idx_nxt;
    logic [2*CODE_LEN-1:0] code_sh;

    tick_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val ('0),
        .en       (tmr_en),
        .down     (1'b0),
        .term     (tmr_term),
        .count    (tmr_count),
        .tc       (tmr_tc)
    );

    // Next digit's LED is precomputed so the LED register switches on the same
    // edge the state enters ON.
    assign idx_nxt = idx_q + IDX_W'(1);
    assign code_sh = code_q >> {idx_nxt, 1'b0};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        code_d   = code_q;
        led_d    = led_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_term = ON_TERM;

        unique case (state_q)
            ST_IDLE: begin
                led_d  = '0;
                busy_d = 1'b0;
                if (start) begin
                    code_d   = code;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    state_d  = ST_ON;
                    led_d    = digit_to_led(code[1:0]);
                    busy_d   = 1'b1;
                end
            end
            ST_ON: begin
                tmr_term = ON_TERM;
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    state_d  = ST_GAP;
                    led_d    = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_GAP: begin
                tmr_term = OFF_TERM;
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        led_d   = '0;
                    end else begin
                        idx_d   = idx_nxt;
                        state_d = ST_ON;
                        led_d   = digit_to_led(code_sh[1:0]);
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            code_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_code_player.sv
// Scoreboard bench for code_player: stimulus queues expected LED frames and
// done pulses, a negedge monitor pops and compares them.
module tb_code_player;
    import code_player_pkg::*;

    localparam int unsigned CODE_LEN  = 5;
    localparam int unsigned ON_TICKS  = 3;
    localparam int unsigned OFF_TICKS = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [2*CODE_LEN-1:0] code;
    logic [3:0]            led;
    logic                  busy;
    logic                  done;

    int vec_cnt;
    int err_cnt;

    logic [3:0] exp_led[$];
    bit         exp_done[$];
    logic       prev_busy;

    // Hand-derived per-digit LED patterns
    logic [3:0] t390 [CODE_LEN] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] t0e4 [CODE_LEN] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    code_player #(
        .CODE_LEN (CODE_LEN),
        .ON_TICKS (ON_TICKS),
        .OFF_TICKS(OFF_TICKS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .code (code),
        .led  (led),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_run(input logic [3:0] tbl [CODE_LEN], input bit with_done);
        for (int i = 0; i < CODE_LEN; i++) begin
            repeat (ON_TICKS) exp_led.push_back(tbl[i]);
            repeat (OFF_TICKS) exp_led.push_back(4'b0000);
        end
        if (with_done) exp_done.push_back(1'b1);
    endtask

    task automatic play(input logic [2*CODE_LEN-1:0] c, input logic [3:0] tbl [CODE_LEN],
                        input bit with_done);
        @(posedge clk);
        #1;
        code  = c;
        start = 1'b1;
        push_run(tbl, with_done);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("latency_busy", {31'd0, busy}, 32'd1);
        check("latency_led", {28'd0, led}, {28'd0, tbl[0]});
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_within_budget", {31'd0, seen}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot_idle_dark", {31'd0, ($onehot0(led) && (busy || led == 4'b0000))}, 32'd1);
            if (busy) begin
                if (exp_led.size() == 0) begin
                    check("busy_unexpected", {31'd0, busy}, 32'd0);
                end else begin
                    check("led_frame", {28'd0, led}, {28'd0, exp_led.pop_front()});
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", {31'd0, done}, 32'd0);
                end else begin
                    void'(exp_done.pop_front());
                    check("done_after_busy", {30'd0, prev_busy, busy}, 32'd2);
                end
            end
        end
        prev_busy = busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        prev_busy = 1'b0;
        rst_n     = 1'b1;
        start     = 1'b0;
        code      = '0;

        #3 rst_n = 1'b0;
        #1;
        check("reset_led", {28'd0, led}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (50) @(posedge clk);
        #1;
        check("idle50_busy", {31'd0, busy}, 32'd0);
        check("idle50_led", {28'd0, led}, 32'd0);

        // Basic playback of the default code
        play(DEFAULT_CODE, t390, 1'b1);
        wait_done(40);
        repeat (3) @(posedge clk);

        // Restarts and code change during playback are ignored
        play(DEFAULT_CODE, t390, 1'b1);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        code = 10'h3FF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(40);
        repeat (3) @(posedge clk);

        // Start in the done cycle begins the next run without an idle gap
        play(DEFAULT_CODE, t390, 1'b1);
        wait_done(40);
        code  = 10'h0E4;
        start = 1'b1;
        push_run(t0e4, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_led", {28'd0, led}, 32'h1);
        wait_done(40);
        repeat (3) @(posedge clk);

        // Reset during the third digit's ON phase
        play(DEFAULT_CODE, t390, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_led", {28'd0, led}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        exp_led.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        // Code covering every LED
        play(10'h0E4, t0e4, 1'b1);
        wait_done(40);
        repeat (5) @(posedge clk);

        check("led_queue_drained", exp_led.size(), 32'd0);
        check("done_queue_drained", exp_done.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
